// File: rtl/sa_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg -- shared definitions for the systolic-array result drain.
//
// Holds the default geometry (element width, array side, register-file lanes),
// the drain FSM state encoding, and small constant helpers used to size the
// beat counter.  The array side and lane count fix the beat count
// B = ceil(ARRAY_DIM*ARRAY_DIM / LANES).
// -----------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_DATA_WIDTH = 16;
  localparam int SA_ARRAY_DIM  = 4;
  localparam int SA_LANES      = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_e;

  // Number of register-file beats needed to move all elements.
  function automatic int sa_num_beats(input int elems, input int lanes);
    return (elems + lanes - 1) / lanes;
  endfunction

  // Beat index width; a single-beat drain still gets a 1-bit index.
  function automatic int sa_beat_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/sa_pull_lane_mux.sv
// -----------------------------------------------------------------------------
// sa_pull_lane_mux -- element-to-lane selection for one register-file beat.
//
// For beat b and lane l the element index is e = b*LANES + l.  Lanes whose
// element index falls past the end of the array are masked: data 0, enable 0.
//
// Build option: define SA_PULL_TRANSPOSE_EN to drain the array column-major,
// i.e. element e reads snapshot[(e % ARRAY_DIM)*ARRAY_DIM + e / ARRAY_DIM].
// Left undefined, element e reads snapshot[e] (row-major).
//
// Ports
//   i_snapshot   captured results, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   i_beat       beat index being presented
//   o_lane_data  per-lane data, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   o_lane_en    per-lane write enable
// -----------------------------------------------------------------------------
module sa_pull_lane_mux
  import sa_pkg::*;
#(
  parameter int DATA_WIDTH = SA_DATA_WIDTH,
  parameter int ARRAY_DIM  = SA_ARRAY_DIM,
  parameter int LANES      = SA_LANES,
  parameter int BEAT_W     = 1
) (
  input  logic [ARRAY_DIM*ARRAY_DIM*DATA_WIDTH-1:0] i_snapshot,
  input  logic [BEAT_W-1:0]                         i_beat,
  output logic [LANES*DATA_WIDTH-1:0]               o_lane_data,
  output logic [LANES-1:0]                          o_lane_en
);

  localparam int ELEMS = ARRAY_DIM * ARRAY_DIM;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    int   w_elem;
    int   w_src_raw;
    int   w_src;
    logic w_in_range;

    assign w_elem     = int'(i_beat) * LANES + l;
    assign w_in_range = (w_elem < ELEMS);

`ifdef SA_PULL_TRANSPOSE_EN
    assign w_src_raw = (w_elem % ARRAY_DIM) * ARRAY_DIM + (w_elem / ARRAY_DIM);
`else
    assign w_src_raw = w_elem;
`endif

    // Clamp so the part-select stays inside the snapshot on masked lanes.
    assign w_src = w_in_range ? w_src_raw : 0;

    assign o_lane_data[l*DATA_WIDTH +: DATA_WIDTH] =
      w_in_range ? i_snapshot[w_src*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_lane_en[l] = w_in_range;
  end

endmodule

// File: rtl/sa_pull_drain.sv
// -----------------------------------------------------------------------------
// sa_pull_drain -- drains a systolic array's result matrix into a register
// file, LANES elements per beat, under a valid/ready handshake.
//
// A pull is accepted only in IDLE while matmul_done is high; the results are
// then captured into a local snapshot so the array may move on.  Beats are
// presented from the cycle after acceptance, one per handshake, and a single
// pull_done cycle follows the last accepted beat.  A start seen at any other
// time is dropped and reported with a one-cycle pull_err pulse.
//
// Build option: SA_PULL_TRANSPOSE_EN (see sa_pull_lane_mux) selects a
// column-major drain order; handshake and timing are unchanged.
//
// Ports
//   clk          clock, rising edge
//   reset_n      asynchronous active-low reset
//   start_pull   pull instruction from the scheduler
//   matmul_done  level, array results valid
//   results      flattened results, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_ready     register file accepts the current beat
//   wr_valid     beat presented
//   wr_data      lane data, lane l at [l*DATA_WIDTH +: DATA_WIDTH]
//   wr_lane_en   per-lane write enable
//   wr_beat      beat index (destination register select)
//   busy         drain in progress (DRAIN or DONE)
//   pull_done    one-cycle pulse after the last beat is accepted
//   pull_err     one-cycle pulse after a rejected start
// -----------------------------------------------------------------------------
module sa_pull_drain
  import sa_pkg::*;
#(
  parameter  int DATA_WIDTH = SA_DATA_WIDTH,
  parameter  int ARRAY_DIM  = SA_ARRAY_DIM,
  parameter  int LANES      = SA_LANES,
  localparam int ELEMS      = ARRAY_DIM * ARRAY_DIM,
  localparam int BEATS      = sa_num_beats(ELEMS, LANES),
  localparam int BEAT_W     = sa_beat_width(BEATS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start_pull,
  input  logic                          matmul_done,
  input  logic [ELEMS*DATA_WIDTH-1:0]   results,
  input  logic                          wr_ready,
  output logic                          wr_valid,
  output logic [LANES*DATA_WIDTH-1:0]   wr_data,
  output logic [LANES-1:0]              wr_lane_en,
  output logic [BEAT_W-1:0]             wr_beat,
  output logic                          busy,
  output logic                          pull_done,
  output logic                          pull_err
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  sa_state_e                     r_state;
  sa_state_e                     w_state_next;
  logic [BEAT_W-1:0]             r_beat;
  logic [ELEMS*DATA_WIDTH-1:0]   r_snapshot;
  logic                          r_pull_err;

  logic                          w_start_ok;
  logic                          w_start_bad;
  logic                          w_draining;
  logic                          w_beat_fire;
  logic                          w_last_beat;
  logic [LANES*DATA_WIDTH-1:0]   w_lane_data;
  logic [LANES-1:0]              w_lane_en;

  assign w_start_ok  = start_pull && matmul_done && (r_state == ST_IDLE);
  assign w_start_bad = start_pull && !w_start_ok;
  assign w_draining  = (r_state == ST_DRAIN);
  assign w_beat_fire = w_draining && wr_ready;
  assign w_last_beat = (r_beat == LAST_BEAT);

  // ---------------------------------------------------------------------------
  // State, beat counter, snapshot and error pulse
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_beat     <= '0;
      // NOTE: the snapshot is deliberately cleared on reset so no stale matrix
      // survives an aborted pull; it is a register bank, not a RAM macro.
      r_snapshot <= '0;
      r_pull_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pull_err <= w_start_bad;

      // Results are sampled exactly once per pull; later changes are ignored.
      if (w_start_ok) begin
        r_snapshot <= results;
      end

      if (w_start_ok) begin
        r_beat <= '0;
      end else if (w_beat_fire) begin
        r_beat <= w_last_beat ? '0 : r_beat + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    wr_valid     = 1'b0;
    busy         = 1'b0;
    pull_done    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        wr_valid = 1'b1;
        busy     = 1'b1;
        if (w_beat_fire && w_last_beat) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        pull_done    = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  sa_pull_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_DIM  (ARRAY_DIM),
    .LANES      (LANES),
    .BEAT_W     (BEAT_W)
  ) u_lane_mux (
    .i_snapshot  (r_snapshot),
    .i_beat      (r_beat),
    .o_lane_data (w_lane_data),
    .o_lane_en   (w_lane_en)
  );

  // Beat payload is only driven while a beat is on offer; it depends on
  // registered state alone, so it holds steady through any wr_ready stall.
  assign wr_data    = w_draining ? w_lane_data : '0;
  assign wr_lane_en = w_draining ? w_lane_en   : '0;
  assign wr_beat    = w_draining ? r_beat      : '0;
  assign pull_err   = r_pull_err;

endmodule

// File: doc/sa_pull_drain.md
SA_PULL_DRAIN -- requirements
Module: sa_pull_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one result element.
REQ-002 SHALL have parameter ARRAY_DIM, default 4, systolic array side; elements E = ARRAY_DIM*ARRAY_DIM.
REQ-003 SHALL have parameter LANES, default 8, register-file write lanes per beat; beats B = ceil(E/LANES).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_pull  input  1  pull instruction issued by scheduler.
REQ-007 SHALL have port matmul_done  input  1  level, systolic array results valid.
REQ-008 SHALL have port results  input  E*DATA_WIDTH  flattened results; element i at bits [i*DATA_WIDTH +: DATA_WIDTH], row-major.
REQ-009 SHALL have port wr_ready  input  1  register file accepts current beat.
REQ-010 SHALL have port wr_valid  output  1  beat presented.
REQ-011 SHALL have port wr_data  output  LANES*DATA_WIDTH  lane l at bits [l*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port wr_lane_en  output  LANES  per-lane write enable.
REQ-013 SHALL have port wr_beat  output  max(1,$clog2(B))  beat index, selects destination register.
REQ-014 SHALL have port busy  output  1  drain in progress.
REQ-015 SHALL have port pull_done  output  1  one-cycle pulse after last beat accepted.
REQ-016 SHALL have port pull_err  output  1  one-cycle pulse on rejected start.

Function
REQ-017 SHALL implement FSM IDLE -> DRAIN -> DONE -> IDLE.
REQ-018 SHALL, in IDLE with start_pull=1 and matmul_done=1 at an edge, copy results into an internal snapshot, clear beat counter, enter DRAIN.
REQ-019 SHALL assert wr_valid only in DRAIN, starting the cycle after acceptance (1-cycle latency).
REQ-020 SHALL drive, for beat b lane l, element index e = b*LANES + l; wr_data lane = snapshot[e], wr_lane_en[l]=1 when e < E, else lane data 0 and enable 0.
REQ-021 SHALL hold wr_data, wr_lane_en, wr_beat stable while wr_valid=1 and wr_ready=0.
REQ-022 SHALL advance the beat counter only on wr_valid && wr_ready; on acceptance of beat B-1 enter DONE.
REQ-023 SHALL assert pull_done for exactly the one DONE cycle, then return to IDLE.
REQ-024 SHALL assert busy in DRAIN and DONE, 0 in IDLE.
REQ-025 SHALL ignore start_pull when not in IDLE, or when matmul_done=0, and pulse pull_err next cycle; state and snapshot unaffected.
REQ-026 SHALL not sample results after snapshot; changes to results during DRAIN do not alter output data.
REQ-027 SHALL hold the beat counter in range 0..B-1; no wrap within one pull.

Reset
REQ-028 SHALL, on reset_n=0 at any time including mid-drain, immediately enter IDLE, clear beat counter and snapshot, drive wr_valid, wr_data, wr_lane_en, wr_beat, busy, pull_done, pull_err to 0.
REQ-029 SHALL resume normal operation at the first edge after reset_n deasserts; no pending beats preserved.

Configuration
REQ-030 SHALL support macro SA_PULL_TRANSPOSE_EN: defined -> element e maps to snapshot[(e % ARRAY_DIM)*ARRAY_DIM + e / ARRAY_DIM] (column-major drain); undefined -> snapshot[e] (row-major); handshake and timing identical.

Structure
REQ-031 SHALL take DATA_WIDTH, ARRAY_DIM, LANES defaults and the FSM state enum from shared package sa_pkg.
REQ-032 SHALL place element-to-lane selection (incl. transpose and lane masking) in sub-module sa_pull_lane_mux; FSM, counter, snapshot in top.

Verification (DATA_WIDTH=16, ARRAY_DIM=4, LANES=8, results[i]=0x0100+i)
REQ-033 SHALL cover: start_pull+matmul_done, wr_ready=1 -> beat0 lanes 0x0100..0x0107, beat1 0x0108..0x010F, wr_lane_en=0xFF, pull_done 3 cycles after start edge.
REQ-034 SHALL cover: wr_ready=0 for 5 cycles on beat0 -> wr_data/wr_beat stable, busy=1, then completes normally.
REQ-035 SHALL cover: start_pull with matmul_done=0, and start_pull during DRAIN -> pull_err pulse, state unchanged.
REQ-036 SHALL cover: reset_n=0 during beat1 -> all outputs 0 immediately; new pull afterwards starts at beat0.
REQ-037 SHALL cover: ARRAY_DIM=3, LANES=4 -> B=3, beat2 wr_lane_en=0x1, lanes 1..3 data 0.
REQ-038 SHALL cover: SA_PULL_TRANSPOSE_EN defined -> beat0 lanes 0x0100,0x0104,0x0108,0x010C,0x0101,0x0105,0x0109,0x010D.
